alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 169 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end sharing one combinational ALU.
// Each accepted operation takes three cycles: IDLE grant, EXEC compute, RESP handshake.

module alu_arbiter_alu #(
  parameter int unsigned width = 4
) (
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  input  logic [2:0]       sel,
  output logic [width-1:0] y,
  output logic [4:0]       flags
);
  logic [width:0] sum;
  logic           carry;
  logic           ovf;

  // Subtraction reports borrow in the carry flag; logic ops clear carry and overflow.
  always_comb begin
    sum   = '0;
    y     = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    unique case (sel)
      3'b000: begin
        sum   = {1'b0, a} + {1'b0, b};
        y     = sum[width-1:0];
        carry = sum[width];
        ovf   = (a[width-1] == b[width-1]) && (y[width-1] != a[width-1]);
      end
      3'b001: begin
        sum   = {1'b0, a} - {1'b0, b};
        y     = sum[width-1:0];
        carry = sum[width];
        ovf   = (a[width-1] != b[width-1]) && (y[width-1] != a[width-1]);
      end
      3'b010: y = a & b;
      3'b011: y = a | b;
      3'b100: y = a ^ b;
      3'b101: y = ~a;
      3'b110: begin
        y     = {a[width-2:0], 1'b0};
        carry = a[width-1];
      end
      3'b111: begin
        y     = {1'b0, a[width-1:1]};
        carry = a[0];
      end
      default: y = '0;
    endcase
    flags = {y[width-1], (y == '0), ovf, ^y, carry};
  end
endmodule

module alu_arbiter #(
  parameter int unsigned width = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [width-1:0] req0_a,
  input  logic [width-1:0] req0_b,
  input  logic [2:0]       req0_sel,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [width-1:0] req1_a,
  input  logic [width-1:0] req1_b,
  input  logic [2:0]       req1_sel,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [width-1:0] resp_y,
  output logic [4:0]       resp_flags,
  output logic             resp_id,
  output logic [15:0]      ops_done
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state;
  state_t           next_state;
  logic             ptr;
  logic             accept;
  logic             gnt_id;
  logic             load_resp;
  logic             done;
  logic [width-1:0] op_a;
  logic [width-1:0] op_b;
  logic [2:0]       op_sel;
  logic             op_id;
  logic [width-1:0] alu_y;
  logic [4:0]       alu_flags;

  alu_arbiter_alu #(.width(width)) u_alu (
    .a    (op_a),
    .b    (op_b),
    .sel  (op_sel),
    .y    (alu_y),
    .flags(alu_flags)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    accept     = 1'b0;
    gnt_id     = 1'b0;
    load_resp  = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rst && (req0_valid || req1_valid)) begin
          accept     = 1'b1;
          gnt_id     = (req0_valid && req1_valid) ? ptr : req1_valid;
          req0_ready = !gnt_id;
          req1_ready = gnt_id;
          next_state = EXEC;
        end
      end
      EXEC: begin
        load_resp  = 1'b1;
        next_state = RESP;
      end
      RESP: begin
        if (resp_valid && resp_ready) begin
          done       = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr        <= 1'b0;
      op_a       <= '0;
      op_b       <= '0;
      op_sel     <= '0;
      op_id      <= 1'b0;
      resp_valid <= 1'b0;
      resp_y     <= '0;
      resp_flags <= '0;
      resp_id    <= 1'b0;
      ops_done   <= '0;
    end else begin
      if (accept) begin
        op_a   <= gnt_id ? req1_a   : req0_a;
        op_b   <= gnt_id ? req1_b   : req0_b;
        op_sel <= gnt_id ? req1_sel : req0_sel;
        op_id  <= gnt_id;
        ptr    <= !gnt_id;
      end
      if (load_resp) begin
        resp_y     <= alu_y;
        resp_flags <= alu_flags;
        resp_id    <= op_id;
        resp_valid <= 1'b1;
      end
      if (done) begin
        resp_valid <= 1'b0;
        ops_done   <= ops_done + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter at width 4.
module tb_alu_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_ready, req1_ready;
  logic [3:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [2:0] req0_sel = '0, req1_sel = '0;
  logic       resp_valid;
  logic       resp_ready = 1'b0;
  logic [3:0] resp_y;
  logic [4:0] resp_flags;
  logic       resp_id;
  logic [15:0] ops_done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.width(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_y(resp_y), .resp_flags(resp_flags),
    .resp_id(resp_id), .ops_done(ops_done)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Presents one request, waits for its grant, scrambles the inputs, then waits for resp_valid.
  task automatic issue(input bit which, input logic [3:0] a, input logic [3:0] b, input logic [2:0] sel,
                       output logic [3:0] y, output logic [4:0] fl, output logic id,
                       output int acc_wait, output int lat);
    @(negedge clk);
    req0_valid = !which; req1_valid = which;
    if (which) begin req1_a = a; req1_b = b; req1_sel = sel; end
    else       begin req0_a = a; req0_b = b; req0_sel = sel; end
    acc_wait = -1;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (which ? req1_ready : req0_ready) begin acc_wait = c; break; end
      @(negedge clk);
    end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = ~a; req0_b = ~b; req0_sel = sel ^ 3'b111;
    req1_a = ~a; req1_b = ~b; req1_sel = sel ^ 3'b111;
    lat = -1;
    for (int c = 1; c < 10; c++) begin
      #1;
      if (resp_valid) begin lat = c; break; end
      @(negedge clk);
    end
    y = resp_y; fl = resp_flags; id = resp_id;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1; resp_ready = 1'b0;
    #1;
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      n_fail++; $display("FAIL reset_ready_async: got %b want 00", {req0_ready, req1_ready});
    end
    @(negedge clk); #1;
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      n_fail++; $display("FAIL reset_ready: got %b want 00", {req0_ready, req1_ready});
    end
    n_checks++;
    if ({resp_valid, resp_y, resp_flags, resp_id, ops_done} !== 27'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%b y=%h flags=%b id=%b ops=%h want all 0",
               resp_valid, resp_y, resp_flags, resp_id, ops_done);
    end
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_req0_add;
    logic [3:0] y; logic [4:0] fl; logic id; int aw, lat;
    do_reset();
    resp_ready = 1'b1;
    issue(1'b0, 4'd7, 4'd1, 3'b000, y, fl, id, aw, lat);
    n_checks++;
    if (aw !== 0 || lat !== 2) begin
      n_fail++; $display("FAIL req0_timing: accept_wait=%0d latency=%0d want 0 and 2", aw, lat);
    end
    n_checks++;
    if ({y, fl, id} !== {4'd8, 5'b10110, 1'b0}) begin
      n_fail++; $display("FAIL req0_add: y=%0d flags=%b id=%b want 8 10110 0", y, fl, id);
    end
    @(negedge clk); #1;
    n_checks++;
    if (resp_valid !== 1'b0 || ops_done !== 16'd1) begin
      n_fail++; $display("FAIL req0_done: valid=%b ops=%0d want 0 1", resp_valid, ops_done);
    end
  endtask

  task automatic test_req1_add;
    logic [3:0] y; logic [4:0] fl; logic id; int aw, lat;
    resp_ready = 1'b1;
    issue(1'b1, 4'd15, 4'd1, 3'b000, y, fl, id, aw, lat);
    n_checks++;
    if (aw !== 0 || lat !== 2 || {y, fl, id} !== {4'd0, 5'b01001, 1'b1}) begin
      n_fail++;
      $display("FAIL req1_add: wait=%0d lat=%0d y=%0d flags=%b id=%b want 0 2 0 01001 1", aw, lat, y, fl, id);
    end
  endtask

  task automatic test_opcodes;
    logic [3:0] va[8] = '{4'd3, 4'd8, 4'd12, 4'd5, 4'd6, 4'd5, 4'd9, 4'd9};
    logic [3:0] vb[8] = '{4'd5, 4'd1, 4'd10, 4'd2, 4'd6, 4'd0, 4'd0, 4'd0};
    logic [2:0] vs[8] = '{3'b001, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
    logic [3:0] ey[8] = '{4'd14, 4'd7, 4'd8, 4'd7, 4'd0, 4'd10, 4'd2, 4'd4};
    logic [4:0] ef[8] = '{5'b10011, 5'b00110, 5'b10010, 5'b00010, 5'b01000, 5'b10000, 5'b00011, 5'b00011};
    logic [3:0] y; logic [4:0] fl; logic id; int aw, lat;
    resp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      issue(i[0], va[i], vb[i], vs[i], y, fl, id, aw, lat);
      n_checks++;
      if ({y, fl, id} !== {ey[i], ef[i], i[0]} || lat !== 2) begin
        n_fail++;
        $display("FAIL opcode_%0d: y=%0d flags=%b id=%b lat=%0d want y=%0d flags=%b id=%b lat=2",
                 i, y, fl, id, lat, ey[i], ef[i], i[0]);
      end
    end
  endtask

  task automatic test_round_robin;
    int gid[8]; int gcyc[8]; int ng = 0; bit both = 0;
    do_reset();
    resp_ready = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int c = 0; c < 18; c++) begin
      #1;
      if (req0_ready && req1_ready) both = 1;
      if ((req0_ready || req1_ready) && ng < 8) begin
        gid[ng] = req1_ready ? 1 : 0; gcyc[ng] = c; ng++;
      end
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    n_checks++;
    if (both || ng != 6) begin
      n_fail++; $display("FAIL rr_count: grants=%0d both_high=%0d want 6 0", ng, both);
    end
    for (int i = 0; i < 6 && i < ng; i++) begin
      n_checks++;
      if (gid[i] != i % 2 || gcyc[i] != 3 * i) begin
        n_fail++;
        $display("FAIL rr_grant_%0d: id=%0d cycle=%0d want id=%0d cycle=%0d", i, gid[i], gcyc[i], i % 2, 3 * i);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [3:0] y; logic [4:0] fl; logic id; int aw, lat;
    do_reset();
    resp_ready = 1'b0;
    issue(1'b0, 4'd2, 4'd3, 3'b100, y, fl, id, aw, lat);
    n_checks++;
    if ({y, fl, id} !== {4'd1, 5'b00010, 1'b0}) begin
      n_fail++; $display("FAIL bp_result: y=%0d flags=%b id=%b want 1 00010 0", y, fl, id);
    end
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = 4'd9; req0_b = 4'd9; req1_a = 4'd4; req1_b = 4'd4;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      n_checks++;
      if (resp_valid !== 1'b1 || {resp_y, resp_flags, resp_id} !== {4'd1, 5'b00010, 1'b0} ||
          ops_done !== 16'd0 || {req0_ready, req1_ready} !== 2'b00) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: valid=%b y=%0d flags=%b id=%b ops=%0d ready=%b%b want 1 1 00010 0 0 00",
                 c, resp_valid, resp_y, resp_flags, resp_id, ops_done, req0_ready, req1_ready);
      end
    end
    resp_ready = 1'b1;
    @(negedge clk); #1;
    n_checks++;
    if (resp_valid !== 1'b0 || ops_done !== 16'd1 || {req0_ready, req1_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL bp_release: valid=%b ops=%0d ready=%b%b want 0 1 01",
               resp_valid, ops_done, req0_ready, req1_ready);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_reset_in_exec;
    do_reset();
    resp_ready = 1'b1;
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 4'd1; req0_b = 4'd1; req0_sel = 3'b000;
    #1;
    n_checks++;
    if (req0_ready !== 1'b1) begin
      n_fail++; $display("FAIL rx_accept: req0_ready=%b want 1", req0_ready);
    end
    @(negedge clk);
    req0_valid = 1'b0; rst = 1'b1;
    @(negedge clk); #1;
    n_checks++;
    if ({resp_valid, resp_y, resp_flags, resp_id, ops_done} !== 27'd0) begin
      n_fail++;
      $display("FAIL rx_cleared: valid=%b y=%h flags=%b id=%b ops=%h want all 0",
               resp_valid, resp_y, resp_flags, resp_id, ops_done);
    end
    rst = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_fail++; $display("FAIL rx_pointer: ready=%b%b want 10", req0_ready, req1_ready);
    end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int c = 0; c < 4; c++) @(negedge clk);
    #1;
    n_checks++;
    if (ops_done !== 16'd1) begin
      n_fail++; $display("FAIL rx_count: ops=%0d want 1", ops_done);
    end
  endtask

  task automatic test_idle_resp_ready;
    do_reset();
    resp_ready = 1'b1;
    for (int c = 0; c < 3; c++) @(negedge clk);
    #1;
    n_checks++;
    if (resp_valid !== 1'b0 || ops_done !== 16'd0) begin
      n_fail++; $display("FAIL idle_resp_ready: valid=%b ops=%0d want 0 0", resp_valid, ops_done);
    end
  endtask

  task automatic test_wrap;
    logic [3:0] y; logic [4:0] fl; logic id; int aw, lat;
    do_reset();
    force dut.ops_done = 16'hFFFF;
    #1;
    release dut.ops_done;
    resp_ready = 1'b1;
    issue(1'b1, 4'd2, 4'd2, 3'b000, y, fl, id, aw, lat);
    n_checks++;
    if (ops_done !== 16'hFFFF || {y, id} !== {4'd4, 1'b1}) begin
      n_fail++; $display("FAIL wrap_pre: ops=%h y=%0d id=%b want ffff 4 1", ops_done, y, id);
    end
    @(negedge clk); #1;
    n_checks++;
    if (ops_done !== 16'h0000 || resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL wrap: ops=%h valid=%b want 0000 0", ops_done, resp_valid);
    end
  endtask

  initial begin
    test_reset();
    test_req0_add();
    test_req1_add();
    test_opcodes();
    test_round_robin();
    test_backpressure();
    test_reset_in_exec();
    test_idle_resp_ready();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
